// File: rtl/seg7_scan_driver_if.sv
// Score-word update channel between the scoring FSM (master) and the
// 7-segment scan driver (slave): valid/ready handshake plus BCD digits and DPs.
interface seg7_scan_driver_if;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic [3:0]  upd_dp;
    logic        upd_ready;

    modport master (
        output upd_valid,
        output upd_data,
        output upd_dp,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_data,
        input  upd_dp,
        output upd_ready
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-phase blanking and
// frame-aligned score updates. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   upd,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [1:0]          digit_sel,
    output logic                frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_d;
    logic             wrap_d;

    logic [15:0]      shadow_data_q;
    logic [3:0]       shadow_dp_q;

    logic [3:0]       lit;
    logic [3:0]       cur_digit;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit stays dark while it and every more-significant digit are zero.
    assign lit[3] = |shadow_data_q[15:12];
    assign lit[2] = |shadow_data_q[15:8];
    assign lit[1] = |shadow_data_q[15:4];
    assign lit[0] = 1'b1;
`else
    assign lit = 4'b1111;
`endif

    assign cur_digit     = shadow_data_q[digit_sel*4 +: 4];
    assign upd.upd_ready = (state_q == BLANK) && (digit_sel == 2'd0) && !rst;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        sel_d  = digit_sel;
        wrap_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            sel_d  = digit_sel + 2'd1;
            wrap_d = (digit_sel == 2'd3);
        end
        state_d = (cnt_d < BLANK_END) ? BLANK : SHOW;

        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == SHOW && lit[digit_sel]) begin
            an_d  = ~(4'b0001 << digit_sel);
            seg_d = bcd_to_seg(cur_digit);
            dp_d  = ~shadow_dp_q[digit_sel];
        end
    end

    // Scan state and display output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            digit_sel  <= 2'd0;
            frame_tick <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_sel  <= sel_d;
            frame_tick <= wrap_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
        end
    end

    // Shadow score word, loaded only inside the digit-0 blank window
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
        end else if (upd.upd_valid && upd.upd_ready) begin
            shadow_data_q <= upd.upd_data;
            shadow_dp_q   <= upd.upd_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Cycle c after reset release has cnt=c%8, digit=(c/8)%4; outputs lag one cycle.
module tb_seg7_scan_driver;
    logic       clk;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_sel;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seg7_scan_driver_if u_if ();

    seg7_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd        (u_if),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.upd_valid = 1'b0;
        u_if.upd_data  = 16'h0000;
        u_if.upd_dp    = 4'h0;
        repeat (3) tick();
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an: got %b want 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg: got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b want 1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_ft: got %b want 0", frame_tick); end
        checks++; if (u_if.upd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", u_if.upd_ready); end
        rst = 1'b0;
        #1;
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", u_if.upd_ready); end
        checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL rel_sel: got %0d want 0", digit_sel); end
        cyc = 0;
    endtask

    task automatic test_update_display();
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h1234;
        u_if.upd_dp    = 4'h0;
        go_to(1);
        u_if.upd_valid = 1'b0;
        go_to(2);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t2_blank_an: got %b want 1111", an); end
        go_to(3);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL t2_d0_an: got %b want 1110", an); end
        checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL t2_d0_seg: got %b want 0011001", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL t2_d0_dp: got %b want 1", dp); end
        go_to(8);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL t2_d0_last_an: got %b want 1110", an); end
        go_to(9);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t2_d1_blank_an: got %b want 1111", an); end
        checks++; if (digit_sel !== 2'd1) begin errors++; $display("FAIL t2_sel1: got %0d want 1", digit_sel); end
        go_to(13);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL t2_d1_an: got %b want 1101", an); end
        checks++; if (seg !== 7'b0110000) begin errors++; $display("FAIL t2_d1_seg: got %b want 0110000", seg); end
        go_to(27);
        checks++; if (an !== 4'b0111) begin errors++; $display("FAIL t2_d3_an: got %b want 0111", an); end
        checks++; if (seg !== 7'b1111001) begin errors++; $display("FAIL t2_d3_seg: got %b want 1111001", seg); end
        go_to(31);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL t2_ft_pre: got %b want 0", frame_tick); end
        go_to(32);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL t2_ft_32: got %b want 1", frame_tick); end
        checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL t2_ft_sel: got %0d want 0", digit_sel); end
        go_to(33);
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL t2_ft_post: got %b want 0", frame_tick); end
        go_to(64);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL t2_ft_64: got %b want 1", frame_tick); end
    endtask

    task automatic test_deferred_update();
        go_to(76);
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h9999;
        u_if.upd_dp    = 4'b0001;
        #1;
        checks++; if (u_if.upd_ready !== 1'b0) begin errors++; $display("FAIL t3_ready_mid: got %b want 0", u_if.upd_ready); end
        go_to(77);
        checks++; if (seg !== 7'b0110000) begin errors++; $display("FAIL t3_d1_hold: got %b want 0110000", seg); end
        go_to(83);
        checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL t3_d2_hold: got %b want 0100100", seg); end
        go_to(95);
        checks++; if (seg !== 7'b1111001) begin errors++; $display("FAIL t3_d3_hold: got %b want 1111001", seg); end
        go_to(96);
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_frame: got %b want 1", u_if.upd_ready); end
        go_to(98);
        u_if.upd_valid = 1'b0;
        go_to(99);
        checks++; if (seg !== 7'b0010000) begin errors++; $display("FAIL t3_d0_seg: got %b want 0010000", seg); end
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL t3_d0_dp: got %b want 0", dp); end
    endtask

    task automatic test_dash_codes();
        go_to(128);
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h00AF;
        u_if.upd_dp    = 4'h0;
        go_to(129);
        u_if.upd_valid = 1'b0;
        go_to(131);
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL t4_d0_seg: got %b want 0111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL t4_d0_dp: got %b want 1", dp); end
        go_to(139);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL t4_d1_an: got %b want 1101", an); end
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL t4_d1_seg: got %b want 0111111", seg); end
        go_to(147);
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t4_d2_an: got %b want 1111", an); end
`else
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL t4_d2_an: got %b want 1011", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL t4_d2_seg: got %b want 1000000", seg); end
`endif
    endtask

    task automatic test_back_to_back_lzb();
        go_to(160);
        u_if.upd_valid = 1'b1;
        u_if.upd_data  = 16'h1111;
        u_if.upd_dp    = 4'h0;
        go_to(161);
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_2nd: got %b want 1", u_if.upd_ready); end
        u_if.upd_data = 16'h0045;
        u_if.upd_dp   = 4'b0001;
        go_to(162);
        checks++; if (u_if.upd_ready !== 1'b0) begin errors++; $display("FAIL t6_ready_show: got %b want 0", u_if.upd_ready); end
        u_if.upd_valid = 1'b0;
        go_to(163);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL t6_d0_an: got %b want 1110", an); end
        checks++; if (seg !== 7'b0010010) begin errors++; $display("FAIL t6_d0_seg: got %b want 0010010", seg); end
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL t6_d0_dp: got %b want 0", dp); end
        go_to(171);
        checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL t6_d1_seg: got %b want 0011001", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL t6_d1_dp: got %b want 1", dp); end
        go_to(179);
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t6_d2_an: got %b want 1111", an); end
`else
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL t6_d2_an: got %b want 1011", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL t6_d2_seg: got %b want 1000000", seg); end
`endif
        go_to(187);
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t6_d3_an: got %b want 1111", an); end
`else
        checks++; if (an !== 4'b0111) begin errors++; $display("FAIL t6_d3_an: got %b want 0111", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL t6_d3_seg: got %b want 1000000", seg); end
`endif
    endtask

    task automatic test_reset_mid_show();
        go_to(212);
        rst = 1'b1;
        tick();
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t5_an: got %b want 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL t5_seg: got %h want 7f", seg); end
        checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL t5_sel: got %0d want 0", digit_sel); end
        checks++; if (u_if.upd_ready !== 1'b0) begin errors++; $display("FAIL t5_ready: got %b want 0", u_if.upd_ready); end
        rst = 1'b0;
        #1;
        cyc = 0;
        checks++; if (u_if.upd_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_rel: got %b want 1", u_if.upd_ready); end
        go_to(3);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL t5_d0_an: got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL t5_d0_seg: got %b want 1000000", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL t5_d0_dp: got %b want 1", dp); end
        go_to(19);
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL t5_d2_an: got %b want 1111", an); end
`else
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL t5_d2_an: got %b want 1011", an); end
`endif
    endtask

    initial begin
        test_reset();
        test_update_display();
        test_deferred_update();
        test_dash_codes();
        test_back_to_back_lzb();
        test_reset_mid_show();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
